// File: rtl/lsu_bridge_if.sv
// Core-side memory port and word-wide request/ready bus of the load/store bridge.
// The bridge uses the slave view; the core and bus environment use the master view.
interface lsu_bridge_if;
   logic [31:0] address;
   logic [31:0] write_data;
   logic        read_enable;
   logic        write_enable;
   logic [1:0]  write_wstrb;
   logic [31:0] read_data;
   logic        mem_stall;
   logic        mem_valid;
   logic        bus_error;
   logic        misalign;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ready;
   logic [31:0] bus_rdata;

   modport slave (
      input  address, write_data, read_enable, write_enable, write_wstrb,
      input  bus_ready, bus_rdata,
      output read_data, mem_stall, mem_valid, bus_error, misalign,
      output bus_req, bus_we, bus_addr, bus_wdata, bus_be
   );

   modport master (
      output address, write_data, read_enable, write_enable, write_wstrb,
      output bus_ready, bus_rdata,
      input  read_data, mem_stall, mem_valid, bus_error, misalign,
      input  bus_req, bus_we, bus_addr, bus_wdata, bus_be
   );
endinterface

// File: rtl/lsu_bridge.sv
// Load/store bridge: latches one core access, drives it onto the request/ready bus
// with lane alignment and byte enables. Macro LSU_MISALIGN_TRAP_EN traps misaligned accesses.
module lsu_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input logic         clock,
   input logic         reset,
   lsu_bridge_if.slave lsu
);
   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t     state;
   logic [7:0] tmo_cnt;
   logic [1:0] off_q;
   logic       we_q;
   logic       req_present;
   logic [1:0] acc_off;
   logic       acc_mis;

   function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'd0:    return 4'b0001 << off;
         2'd1:    return 4'b0011 << off;
         default: return 4'b1111;
      endcase
   endfunction

`ifdef LSU_MISALIGN_TRAP_EN
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'd0:    return 1'b0;
         2'd1:    return off[0];
         default: return off != 2'b00;
      endcase
   endfunction
`else
   function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'd0:    return off;
         2'd1:    return {off[1], 1'b0};
         default: return 2'b00;
      endcase
   endfunction
`endif

   assign req_present   = lsu.read_enable | lsu.write_enable;
   assign lsu.mem_stall = ((state == IDLE) && req_present) || (state == REQ);

   always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
      acc_off = lsu.address[1:0];
      acc_mis = is_misaligned(lsu.write_wstrb, lsu.address[1:0]);
`else
      acc_off = align_off(lsu.write_wstrb, lsu.address[1:0]);
      acc_mis = 1'b0;
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         tmo_cnt       <= 8'd0;
         off_q         <= 2'b00;
         we_q          <= 1'b0;
         lsu.read_data <= 32'd0;
         lsu.mem_valid <= 1'b0;
         lsu.bus_error <= 1'b0;
         lsu.misalign  <= 1'b0;
         lsu.bus_req   <= 1'b0;
         lsu.bus_we    <= 1'b0;
         lsu.bus_addr  <= 32'd0;
         lsu.bus_wdata <= 32'd0;
         lsu.bus_be    <= 4'd0;
      end else begin
         // Status flags live for exactly the one DONE cycle.
         lsu.mem_valid <= 1'b0;
         lsu.bus_error <= 1'b0;
         lsu.misalign  <= 1'b0;
         case (state)
            IDLE: begin
               if (req_present) begin
                  off_q   <= acc_off;
                  we_q    <= lsu.write_enable;
                  tmo_cnt <= 8'd0;
                  if (acc_mis) begin
                     state         <= DONE;
                     lsu.mem_valid <= 1'b1;
                     lsu.misalign  <= 1'b1;
                     lsu.read_data <= 32'd0;
                  end else begin
                     state         <= REQ;
                     lsu.bus_req   <= 1'b1;
                     lsu.bus_we    <= lsu.write_enable;
                     lsu.bus_addr  <= {lsu.address[31:2], 2'b00};
                     lsu.bus_wdata <= lsu.write_data << {acc_off, 3'b000};
                     lsu.bus_be    <= lsu.write_enable ? lane_be(lsu.write_wstrb, acc_off) : 4'd0;
                  end
               end
            end
            REQ: begin
               // A ready on the final allowed cycle still completes normally.
               if (lsu.bus_ready || (tmo_cnt == TMO_LAST)) begin
                  state         <= DONE;
                  lsu.mem_valid <= 1'b1;
                  lsu.bus_error <= ~lsu.bus_ready;
                  lsu.read_data <= (lsu.bus_ready && !we_q) ?
                                   (lsu.bus_rdata >> {off_q, 3'b000}) : 32'd0;
                  lsu.bus_req   <= 1'b0;
                  lsu.bus_we    <= 1'b0;
                  lsu.bus_wdata <= 32'd0;
                  lsu.bus_be    <= 4'd0;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: doc/lsu_bridge.md
# lsu_bridge

Load/store bridge between the core's single-cycle data-memory port and a word-wide request/ready data bus. It latches one load or store, aligns byte lanes and generates byte enables. It holds the core with `mem_stall` until the bus answers or a timeout fires. It returns load data right-justified so the core's existing `wb_mask` logic can apply unchanged.

## Interface

**Parameters**
- `TIMEOUT_CYCLES`, default 16: maximum cycles in REQ before abort; range 1..255.

**Ports** (clock and reset first)
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `address` in 32: byte address from the core.
- `write_data` in 32: store data from the core, right-justified.
- `read_enable` in 1: load request.
- `write_enable` in 1: store request.
- `write_wstrb` in 2: access size; 0 = byte, 1 = half, 2 = word, 3 = treated as word.
- `read_data` out 32: load data, right-justified, registered.
- `mem_stall` out 1: core must hold its PC and request while high.
- `mem_valid` out 1: one-cycle completion pulse.
- `bus_error` out 1: set with `mem_valid` when the access timed out.
- `misalign` out 1: set with `mem_valid` when the access was misaligned.
- `bus_req` out 1: bus request.
- `bus_we` out 1: bus write.
- `bus_addr` out 32: word-aligned address, bits [1:0] = 0.
- `bus_wdata` out 32: lane-aligned store data.
- `bus_be` out 4: byte enables.
- `bus_ready` in 1: bus completion.
- `bus_rdata` in 32: read data, valid when `bus_ready` = 1.

## Operation

**States: IDLE, REQ, DONE.**
- **IDLE:** a request (`read_enable` or `write_enable`) is accepted. Accepting it latches `address`, size, direction and `write_data`. Next state is REQ, or DONE for a trapped misaligned access.
- **Write priority:** if `read_enable` and `write_enable` are both high, the access is a write. `read_data` is then 0.
- **REQ:** `bus_req` = 1. The timeout counter increments each cycle.
  - `bus_ready` = 1 leads to DONE. On a read, `read_data` captures `bus_rdata >> (8*addr[1:0])`.
  - Counter reaching `TIMEOUT_CYCLES` without `bus_ready` leads to DONE with `bus_error` = 1 and `read_data` = 0.
- **DONE:** `mem_valid` = 1 and `mem_stall` = 0; the core advances on this edge. Next state is always IDLE. The still-present request of the completed instruction is not re-accepted.
- **Stall:** `mem_stall` = (IDLE and a request is present) or REQ. It is combinational, so the core stalls in the same cycle it issues the request.

**Lane rules** (a = latched address)
- `bus_addr` = {a[31:2], 2'b00}.
- `bus_wdata` = `write_data` << (8*a[1:0]).
- `bus_be`: byte = 4'b0001 << a[1:0]; half = 4'b0011 << a[1:0]; word = 4'b1111.
- `bus_be` = 0 and `bus_we` = 0 on reads. `bus_wdata` = 0 outside REQ.

**Misalignment**
- An access is misaligned when it is a half with a[0] = 1, or a word with a[1:0] != 0.
- Handling depends on the macro; see Configuration.

## Timing

**Reset values:** state IDLE. `read_data`, `bus_wdata`, `bus_addr` and `bus_be` are 0. `mem_valid`, `bus_error`, `misalign`, `bus_req` and `bus_we` are 0.

**Reset mid-operation:** the FSM returns to IDLE on that edge and `bus_req` drops. No `mem_valid` pulse is issued; a late `bus_ready` is ignored.

**Latency**
- With `bus_ready` in the first REQ cycle: request in cycle 0 (IDLE), REQ in cycle 1, DONE in cycle 2. The core is stalled for 2 cycles.
- Each wait cycle adds 1.
- Timeout: DONE follows REQ after exactly `TIMEOUT_CYCLES` REQ cycles.

**Bus outputs:** held constant for the whole REQ period. `bus_ready` is sampled only in REQ.

**Back-to-back:** a new request may be accepted in the IDLE cycle right after DONE. This gives a minimum of 3 cycles per access.

**Status flags:** `bus_error` and `misalign` are valid only while `mem_valid` = 1, and are 0 otherwise.

## Configuration

Macro: `LSU_MISALIGN_TRAP_EN`.

- **Defined:** a misaligned access issues no bus transaction. It goes from IDLE directly to DONE in the next cycle with `misalign` = 1, `read_data` = 0 and no store performed.
- **Undefined:** low address bits are forced to alignment before use (half clears a[0], word clears a[1:0]). The access proceeds normally and `misalign` is tied to 0.

## Test plan

1. **Word load, immediate ready:** word read at 0x100, `bus_rdata` = 0xDEADBEEF with `bus_ready` in the first REQ cycle -> `bus_addr` = 0x100, `bus_be` = 0; `mem_stall` high 2 cycles; `mem_valid` pulse with `read_data` = 0xDEADBEEF.
2. **Byte store, 3 wait cycles:** byte store at 0x103 with `write_data` = 0x000000A5, `bus_ready` after 3 wait cycles -> `bus_addr` = 0x100, `bus_be` = 4'b1000, `bus_wdata` = 0xA5000000, `bus_we` = 1; `mem_valid` 5 cycles after the request.
3. **Half load, upper half:** half read at 0x202, `bus_rdata` = 0x1234ABCD -> `read_data` = 0x00001234.
4. **Timeout:** `TIMEOUT_CYCLES` = 4, `bus_ready` never asserted -> `bus_req` high exactly 4 cycles, then `mem_valid` with `bus_error` = 1 and `read_data` = 0.
5. **Misaligned word:** word read at 0x101.
   - With `LSU_MISALIGN_TRAP_EN`: `bus_req` never rises; `mem_valid` next cycle with `misalign` = 1.
   - Without it: `bus_addr` = 0x100, `misalign` = 0.
6. **Reset during REQ and simultaneous enables:** reset asserted during REQ, then `bus_ready` -> no `mem_valid`, state IDLE. Then `read_enable` and `write_enable` high together -> `bus_we` = 1.
